// File: rtl/sim_meas_pkg.sv
// Shared types for the measurement-done generators: FSM state encoding and result codes.
package sim_meas_pkg;

    localparam int unsigned CNT_W_MAX = 32;

    // settle_cyc value reported on timeout or abort
    localparam logic [CNT_W_MAX-1:0] SETTLE_FAIL_CODE = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } meas_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter
    import sim_meas_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_c = cnt_d;

endmodule

// File: rtl/sim_done_gen.sv
// Sticky per-measurement done flag: passes after SETTLE_CNT consecutive in_tol cycles,
// fails on timeout or abort, and reports the cycle at which the qualifying run began.
module sim_done_gen
    import sim_meas_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned BLANK_CYC  = 8,
    parameter int unsigned SETTLE_CNT = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             in_tol,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] settle_cyc
);

    localparam int unsigned CNT_MAX      = (32'd1 << CNT_W) - 32'd1;
    localparam int unsigned TIMEOUT_SAT  = ((TIMEOUT - 1) > CNT_MAX) ? CNT_MAX : (TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_CYC > 1) ? (BLANK_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CNT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_SAT);
    localparam logic [CNT_W-1:0] FAIL_CODE    = CNT_W'(SETTLE_FAIL_CODE);
    // With one or zero blanking cycles the first tracked sample is the one after start
    localparam meas_state_e START_STATE = (BLANK_CYC <= 1) ? TRACK : BLANK;

    meas_state_e      state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cand_now;

    logic             elapsed_clr, elapsed_en;
    logic             run_clr, run_en;
    logic [CNT_W-1:0] elapsed_nxt;
    logic [CNT_W-1:0] elapsed_cnt_unused;
    logic [CNT_W-1:0] run_q, run_nxt;

    sat_counter #(.CNT_W(CNT_W)) u_elapsed (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (elapsed_clr),
        .en_i  (elapsed_en),
        .cnt_o (elapsed_cnt_unused),
        .nxt_c (elapsed_nxt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_run (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (run_clr),
        .en_i  (run_en),
        .cnt_o (run_q),
        .nxt_c (run_nxt)
    );

    // Next-state and registered-output logic; elapsed_nxt is the cycle index since start
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        settle_d = settle_q;
        cand_d   = cand_q;
        busy_d   = busy_q;

        elapsed_clr = start;
        elapsed_en  = (state_q == BLANK) || (state_q == TRACK);
        run_clr     = start || ((state_q == TRACK) && !in_tol);
        run_en      = (state_q == TRACK) && in_tol;
        cand_now    = (run_en && (run_q == '0)) ? elapsed_nxt : cand_q;

        if (start) begin
            state_d  = START_STATE;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            settle_d = '0;
            cand_d   = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (abort) begin
                        state_d  = DONE;
                        fail_d   = 1'b1;
                        settle_d = FAIL_CODE;
                    end else if (elapsed_nxt >= BLANK_LAST) begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    cand_d = cand_now;
                    if (abort) begin
                        state_d  = DONE;
                        fail_d   = 1'b1;
                        settle_d = FAIL_CODE;
                    end else if (run_en && (run_nxt >= SETTLE_LAST)) begin
                        state_d  = DONE;
                        pass_d   = 1'b1;
                        settle_d = cand_now;
                    end else if (elapsed_nxt >= TIMEOUT_LAST) begin
                        state_d  = DONE;
                        fail_d   = 1'b1;
                        settle_d = FAIL_CODE;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == BLANK) || (state_d == TRACK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            settle_q <= '0;
            cand_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            settle_q <= settle_d;
            cand_q   <= cand_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign settle_cyc = settle_q;

endmodule
